aes_decipher: RTL

AES_DECIPHER -- requirements
Module: aes_decipher

---
 rtl/aes_decipher.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decipher.sv
// aes_decipher: iterative FIPS-197 AES-128 inverse cipher, one inverse round per clock.
// Optional define AES_DEC_KEYCACHE_EN keeps round key 10 of the last key so a repeat key skips expansion.

`timescale 1ns/1ps

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Entry 0 sits in the most significant byte, hence the inverted index.
  assign y_o = TBL[{~a_i, 3'b000} +: 8];
endmodule

module aes_decipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] dataout
);
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_e;

  state_e       fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q, key_q, dout_q;
  logic         busy_q, done_q;

  logic [31:0]  w0, w1, w2, w3, iw0, iw1, iw2, iw3, fw0, fw1, fw2, fw3;
  logic [31:0]  sb_in, sb_out, kx;
  logic [3:0]   rc_j;
  logic [127:0] fwd_key_d, inv_key_d, ark_d, rnd_d;
  logic         hit;
  logic [127:0] hit_rk10;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] inv_sb(input logic [7:0] b);
    return INV_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sb(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] m2, m4, m8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      m2    = xt(a[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      m9[i] = m8 ^ a[i];
      mb[i] = m8 ^ m2 ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // One set of four S-boxes serves the forward step in KEYEXP and the inverse step in ROUND.
  always_comb begin
    w0    = key_q[127:96];
    w1    = key_q[95:64];
    w2    = key_q[63:32];
    w3    = key_q[31:0];
    iw3   = w3 ^ w2;
    iw2   = w2 ^ w1;
    iw1   = w1 ^ w0;
    sb_in = (fsm_q == ROUND) ? {iw3[23:0], iw3[31:24]} : {w3[23:0], w3[31:24]};
    rc_j  = (fsm_q == ROUND) ? (4'd10 - cnt_q) : (cnt_q + 4'd1);
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(sb_in[8*g +: 8]), .y_o(sb_out[8*g +: 8]));
  end

  always_comb begin
    kx        = sb_out ^ {rcon(rc_j), 24'h000000};
    iw0       = w0 ^ kx;
    fw0       = w0 ^ kx;
    fw1       = w1 ^ fw0;
    fw2       = w2 ^ fw1;
    fw3       = w3 ^ fw2;
    fwd_key_d = {fw0, fw1, fw2, fw3};
    inv_key_d = {iw0, iw1, iw2, iw3};
    ark_d     = inv_sub_bytes(inv_shift_rows(st_q)) ^ inv_key_d;
    rnd_d     = (cnt_q == 4'd9) ? ark_d : inv_mix_columns(ark_d);
  end

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] ck_key_q, ck_rk10_q, op_key_q, op_rk10_q;
  logic         ck_vld_q;

  assign hit      = ck_vld_q && (key == ck_key_q);
  assign hit_rk10 = ck_rk10_q;

  // The in-flight key pair is committed only at done, so an aborted run never pollutes the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_key_q  <= '0;
      ck_rk10_q <= '0;
      op_key_q  <= '0;
      op_rk10_q <= '0;
      ck_vld_q  <= 1'b0;
    end else begin
      if (fsm_q == IDLE && start) op_key_q <= key;
      if (fsm_q == KEYEXP && cnt_q == 4'd10) op_rk10_q <= key_q;
      if (fsm_q == ROUND && cnt_q == 4'd9) begin
        ck_key_q  <= op_key_q;
        ck_rk10_q <= op_rk10_q;
        ck_vld_q  <= 1'b1;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_rk10 = '0;
`endif

  // KEYEXP runs ten schedule steps then one load cycle; a cache hit enters directly at the load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      cnt_q  <= 4'd0;
      st_q   <= '0;
      key_q  <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            st_q   <= datain;
            key_q  <= hit ? hit_rk10 : key;
            cnt_q  <= hit ? 4'd10 : 4'd0;
            busy_q <= 1'b1;
            fsm_q  <= KEYEXP;
          end
        end
        KEYEXP: begin
          if (cnt_q == 4'd10) begin
            st_q  <= st_q ^ key_q;
            cnt_q <= 4'd0;
            fsm_q <= ROUND;
          end else begin
            key_q <= fwd_key_d;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          st_q  <= rnd_d;
          key_q <= inv_key_d;
          if (cnt_q == 4'd9) begin
            dout_q <= rnd_d;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            fsm_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataout = dout_q;
endmodule
